alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised EX-stage ALU for the 5-stage pipeline. Registered 1-cycle result for simple ops and an
//  iterative multi-cycle MUL with valid/ready handshake. Internal N/V/Z flag register with per-opcode
//  write masks. A flush input aborts an in-flight MUL. Sits between the ID/EX and EX/MEM registers.
// PARAMETERS
//  WIDTH    16  datapath width (even, >=8); shift amount = input_B[$clog2(WIDTH)-1:0]
//  IMM_W     8  immediate width for LLB/LHB/mem offset (<= WIDTH/2)
//  LANE_W    4  PADDSB/RED lane width (divides WIDTH)
//  MUL_EN    1  0: MUL decodes as illegal (out=0, no flag write, 1-cycle)
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       reset, synchronous, active-high
//  flush     in   1       kill in-flight MUL / pending result (branch mispredict)
//  in_valid  in   1       opcode/operands valid this cycle
//  in_ready  out  1       unit can accept an op (low while MUL busy)
//  opcode    in   4       operation select (alu_pkg encodings)
//  input_A   in   WIDTH   rs / base address / rd for LLB,LHB
//  input_B   in   WIDTH   rt / shift amount / store data
//  imm       in   IMM_W   immediate / memory offset
//  out_valid out  1       one-cycle pulse: out valid
//  out       out  WIDTH   result
//  flag      out  3       {N,V,Z} from flag register
//  busy      out  1       MUL iteration in progress
// BEHAVIOUR
//  Reset: out=0, out_valid=0, flag=3'b000, busy=0, in_ready=1. Reset mid-MUL aborts it; no flag write.
//  Encodings: 0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB,
//   1000 LW, 1001 SW, 1010 LHB, 1011 LLB, 1100 MUL, others illegal (out=0, no flag write).
//  Accept = in_valid & in_ready. Non-MUL: out, out_valid, flag update on the next edge (latency 1).
//  MUL: busy=1, in_ready=0 for WIDTH cycles (radix-2 shift-add, signed); out_valid pulses on edge
//   WIDTH+1 after accept. in_ready returns 1 in the same cycle out_valid=1 (back-to-back accepted).
//  ADD/SUB: saturating signed; V=1 on saturation; N=sign of saturated result.
//  RED: signed sum of all LANE_W lanes of A and B, sign-extended to WIDTH.
//  PADDSB: per-lane saturating signed add, no carry between lanes.
//  SLL/SRA/ROR: shift input_A by input_B[$clog2(WIDTH)-1:0]; ROR wraps mod WIDTH.
//  LW/SW: out = (input_A & ~1) + (sign_ext(imm) << 1), wrap-around, no flags.
//  LLB: out = {A[WIDTH-1:IMM_W], imm}; LHB: out = {imm, A[WIDTH-IMM_W-1:0]} (IMM_W = WIDTH/2 case).
//  MUL: out = low WIDTH bits of signed product; V=1 if the product does not fit in WIDTH signed.
//  Flag write mask {N,V,Z}: ADD/SUB 111; XOR/SLL/SRA/ROR 001; MUL 111; all others 000.
//   Z = (out == 0). Unmasked bits hold their value.
//  flush: clears busy and pending out_valid in that cycle, no flag write, in_ready=1 next cycle.
//   flush with in_valid in the same cycle: the new op is dropped.
//  in_valid while in_ready=0: ignored; upstream must hold.
// STRUCTURE
//  alu_pkg: opcode localparams, flag bit indices (FLAG_N=2, FLAG_V=1, FLAG_Z=0), flag-mask function.
//  Sub-module alu_mul_iter (start, A, B -> done, product[2*WIDTH-1:0], flush/rst aware).
//  Flag register is inline, not a separate module.
// TESTING
//  ADD 16'h7FFF+16'h0001 -> out=16'h7FFF, flag=3'b010 one cycle later; SUB 5-5 -> out=0, flag=3'b001.
//  MUL 16'h0003*16'hFFFE -> in_ready low 16 cycles, out_valid on cycle 17, out=16'hFFFA, flag=3'b100.
//  MUL 16'h0100*16'h0100 -> out=16'h0000, V=1, Z=1; back-to-back ADD accepted on the out_valid cycle.
//  XOR then PADDSB (A=16'h7777, B=16'h1111 -> 16'h7777 saturated lanes): Z/N/V held after PADDSB.
//  flush at cycle 5 of MUL -> no out_valid, flag unchanged, in_ready=1 next cycle; repeat with rst.
//  ROR A=16'h8001 by 1 -> 16'hC000; LLB A=16'hABCD imm=8'h12 -> 16'hAB12; LW A=16'h1001 imm=8'hFF -> 16'h0FFE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and the per-opcode flag write mask.
package alu_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;
   localparam logic [3:0] OP_LHB    = 4'b1010;
   localparam logic [3:0] OP_LLB    = 4'b1011;
   localparam logic [3:0] OP_MUL    = 4'b1100;

   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic [0:0] {
      MUL_IDLE = 1'b0,
      MUL_RUN  = 1'b1
   } mul_state_e;

   // Which of {N,V,Z} an opcode is allowed to update; unmasked bits hold.
   function automatic logic [2:0] flag_mask(input logic [3:0] op);
      logic [2:0] m;
      m = 3'b000;
      case (op)
         OP_ADD, OP_SUB, OP_MUL:          m = 3'b111;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR:  m = 3'b001;
         default:                         m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative radix-2 signed shift-add multiplier.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  MUL_IDLE | waiting for start; done low
//  MUL_RUN  | one multiplier bit per cycle, cnt counts remaining bits
//
// Bit 0 is folded into the load so that WIDTH-1 run cycles remain; done
// is a one-cycle registered pulse, which lets the parent register the
// result exactly WIDTH cycles after start.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   mul_state_e         state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;

   // Sequencer: load on start, accumulate one partial product per cycle, MSB weight negative.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state   <= MUL_IDLE;
         done    <= 1'b0;
         cnt     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            MUL_IDLE: begin
               if (start) begin
                  product <= b[0] ? {{WIDTH{a[WIDTH-1]}}, a} : '0;
                  mcand   <= {{WIDTH{a[WIDTH-1]}}, a} << 1;
                  mplier  <= b >> 1;
                  cnt     <= CW'(WIDTH - 1);
                  state   <= MUL_RUN;
               end
            end
            MUL_RUN: begin
               if (mplier[0]) begin
                  if (cnt == CW'(1)) product <= product - mcand;
                  else               product <= product + mcand;
               end
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  done  <= 1'b1;
                  state <= MUL_IDLE;
               end
            end
            default: state <= MUL_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle registered ops, iterative MUL, masked N/V/Z flag register.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int IMM_W  = 8,
   parameter int LANE_W = 4,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] input_A,
   input  logic [WIDTH-1:0] input_B,
   input  logic [IMM_W-1:0] imm,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic [2:0]       flag,
   output logic             busy
);

   localparam int SHW   = $clog2(WIDTH);
   localparam int LANES = WIDTH / LANE_W;
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic               accept;
   logic               is_mul;
   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   sum_ab;
   logic [WIDTH-1:0]   dif_ab;
   logic [WIDTH-1:0]   imm_ext;
   logic [WIDTH-1:0]   red_res;
   logic [WIDTH-1:0]   padd_res;
   logic [WIDTH-1:0]   res;
   logic               res_ovf;
   logic [2:0]         res_mask;
   logic [2:0]         res_flag;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   logic               mul_ovf;
   logic [2:0]         mul_flag;

   assign in_ready = ~busy;
   assign is_mul   = (opcode == OP_MUL) && (MUL_EN != 0);
   // A flush in the accept cycle drops the incoming op.
   assign accept   = in_valid & in_ready & ~flush;
   assign shamt    = input_B[SHW-1:0];
   assign sum_ab   = input_A + input_B;
   assign dif_ab   = input_A - input_B;
   assign imm_ext  = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .start   (accept & is_mul),
      .a       (input_A),
      .b       (input_B),
      .done    (mul_done),
      .product (mul_prod)
   );

   // Product overflows when the upper half plus the result sign bit is not a pure sign extension.
   assign mul_ovf  = ~((&mul_prod[2*WIDTH-1:WIDTH-1]) | ~(|mul_prod[2*WIDTH-1:WIDTH-1]));
   assign mul_flag = {mul_prod[WIDTH-1], mul_ovf, (mul_prod[WIDTH-1:0] == '0)};

   // Lane reduction and lane-wise saturating add; lanes never carry into each other.
   always_comb begin
      logic [LANE_W-1:0] la;
      logic [LANE_W-1:0] lb;
      logic [LANE_W:0]   ls;
      red_res  = '0;
      padd_res = '0;
      la       = '0;
      lb       = '0;
      ls       = '0;
      for (int i = 0; i < LANES; i++) begin
         la = input_A[i*LANE_W +: LANE_W];
         lb = input_B[i*LANE_W +: LANE_W];
         red_res = red_res + {{(WIDTH-LANE_W){la[LANE_W-1]}}, la}
                           + {{(WIDTH-LANE_W){lb[LANE_W-1]}}, lb};
         ls = {la[LANE_W-1], la} + {lb[LANE_W-1], lb};
         if (ls[LANE_W] != ls[LANE_W-1])
            padd_res[i*LANE_W +: LANE_W] = ls[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                                      : {1'b0, {(LANE_W-1){1'b1}}};
         else
            padd_res[i*LANE_W +: LANE_W] = ls[LANE_W-1:0];
      end
   end

   // Single-cycle result select; illegal opcodes (and MUL when disabled) give zero.
   always_comb begin
      res     = '0;
      res_ovf = 1'b0;
      case (opcode)
         OP_ADD: begin
            res_ovf = (input_A[WIDTH-1] == input_B[WIDTH-1]) && (sum_ab[WIDTH-1] != input_A[WIDTH-1]);
            res     = res_ovf ? (input_A[WIDTH-1] ? SMIN : SMAX) : sum_ab;
         end
         OP_SUB: begin
            res_ovf = (input_A[WIDTH-1] != input_B[WIDTH-1]) && (dif_ab[WIDTH-1] != input_A[WIDTH-1]);
            res     = res_ovf ? (input_A[WIDTH-1] ? SMIN : SMAX) : dif_ab;
         end
         OP_XOR:        res = input_A ^ input_B;
         OP_RED:        res = red_res;
         OP_SLL:        res = input_A << shamt;
         OP_SRA:        res = $signed(input_A) >>> shamt;
         OP_ROR:        res = WIDTH'({input_A, input_A} >> shamt);
         OP_PADDSB:     res = padd_res;
         OP_LW, OP_SW:  res = {input_A[WIDTH-1:1], 1'b0} + (imm_ext << 1);
         OP_LHB:        res = {imm, input_A[WIDTH-IMM_W-1:0]};
         OP_LLB:        res = {input_A[WIDTH-1:IMM_W], imm};
         default:       res = '0;
      endcase
   end

   assign res_mask = (opcode == OP_MUL) ? 3'b000 : flag_mask(opcode);
   assign res_flag = {res[WIDTH-1], res_ovf, (res == '0)};

   // Output, handshake and flag register; MUL completion takes priority over a new accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         flag      <= 3'b000;
         busy      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (flush) begin
            busy <= 1'b0;
         end else if (busy) begin
            if (mul_done) begin
               out       <= mul_prod[WIDTH-1:0];
               out_valid <= 1'b1;
               busy      <= 1'b0;
               flag      <= (flag & ~flag_mask(OP_MUL)) | (mul_flag & flag_mask(OP_MUL));
            end
         end else if (accept) begin
            if (is_mul) begin
               busy <= 1'b1;
            end else begin
               out       <= res;
               out_valid <= 1'b1;
               flag      <= (flag & ~res_mask) | (res_flag & res_mask);
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (WIDTH=16, IMM_W=8, LANE_W=4).
module tb_alu_exec_unit;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic [15:0] input_A;
   logic [15:0] input_B;
   logic [7:0]  imm;
   logic        out_valid;
   logic [15:0] out;
   logic [2:0]  flag;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   alu_exec_unit #(.WIDTH(16), .IMM_W(8), .LANE_W(4), .MUL_EN(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .input_A   (input_A),
      .input_B   (input_B),
      .imm       (imm),
      .out_valid (out_valid),
      .out       (out),
      .flag      (flag),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] im);
      opcode   = op;
      input_A  = a;
      input_B  = b;
      imm      = im;
      in_valid = 1'b1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] im);
      drive(op, a, b, im);
      tick();
      in_valid = 1'b0;
   endtask

   // Runs one single-cycle op and checks result, pulse and flags.
   task automatic op1(input string tag, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [7:0] im,
                      input logic [15:0] exp_out, input logic [2:0] exp_flag);
      issue(op, a, b, im);
      check({tag, "_out"}, out, exp_out);
      check({tag, "_vld"}, out_valid, 1'b1);
      check({tag, "_flag"}, flag, exp_flag);
   endtask

   // Waits for out_valid with a cycle budget; reports cycles and in_ready-low cycles seen.
   task automatic wait_out(output int cyc, output int low);
      cyc = 0;
      low = 0;
      while (!out_valid && cyc < 40) begin
         if (!in_ready) low++;
         tick();
         cyc++;
      end
   endtask

   // Counts out_valid pulses over a fixed window.
   task automatic count_pulses(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         if (out_valid) pulses++;
         tick();
      end
   endtask

   int cyc;
   int low;
   int pulses;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
      opcode = 4'h0; input_A = '0; input_B = '0; imm = '0;
      tick(); tick(); tick();
      rst = 1'b0;
      check("rst_out", out, 16'h0000);
      check("rst_vld", out_valid, 1'b0);
      check("rst_flag", flag, 3'b000);
      check("rst_busy", busy, 1'b0);
      check("rst_rdy", in_ready, 1'b1);

      op1("add_sat", 4'b0000, 16'h7FFF, 16'h0001, 8'h00, 16'h7FFF, 3'b010);
      tick();
      check("vld_pulse", out_valid, 1'b0);
      op1("sub_zero", 4'b0001, 16'h0005, 16'h0005, 8'h00, 16'h0000, 3'b001);

      // MUL 3 * -2
      issue(4'b1100, 16'h0003, 16'hFFFE, 8'h00);
      check("mul1_busy", busy, 1'b1);
      wait_out(cyc, low);
      check("mul1_lat", cyc, 16);
      check("mul1_lowrdy", low, 16);
      check("mul1_out", out, 16'hFFFA);
      check("mul1_flag", flag, 3'b100);
      check("mul1_rdy", in_ready, 1'b1);
      check("mul1_busy0", busy, 1'b0);
      tick();
      check("mul1_pulse", out_valid, 1'b0);

      // MUL overflow, then ADD issued in the out_valid cycle
      issue(4'b1100, 16'h0100, 16'h0100, 8'h00);
      wait_out(cyc, low);
      check("mul2_lat", cyc, 16);
      check("mul2_out", out, 16'h0000);
      check("mul2_flag", flag, 3'b011);
      op1("b2b_add", 4'b0000, 16'h0002, 16'h0003, 8'h00, 16'h0005, 3'b000);

      op1("add_negsat", 4'b0000, 16'h8000, 16'h8000, 8'h00, 16'h8000, 3'b110);
      op1("xor_z", 4'b0010, 16'h1234, 16'h1234, 8'h00, 16'h0000, 3'b111);
      op1("paddsb_sat", 4'b0111, 16'h7777, 16'h1111, 8'h00, 16'h7777, 3'b111);
      op1("paddsb_neg", 4'b0111, 16'h8888, 16'h8888, 8'h00, 16'h8888, 3'b111);
      op1("paddsb_plain", 4'b0111, 16'h1234, 16'h1111, 8'h00, 16'h2345, 3'b111);

      // flush in the 5th busy cycle of a MUL
      issue(4'b1100, 16'h0003, 16'h0003, 8'h00);
      tick(); tick(); tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_busy", busy, 1'b0);
      check("fl_rdy", in_ready, 1'b1);
      check("fl_vld", out_valid, 1'b0);
      count_pulses(20, pulses);
      check("fl_nopulse", pulses, 0);
      check("fl_flag", flag, 3'b111);

      // op presented together with flush is dropped
      drive(4'b0000, 16'h0001, 16'h0001, 8'h00);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl_drop_vld", out_valid, 1'b0);
      check("fl_drop_flag", flag, 3'b111);

      // multiplier usable again after abort
      issue(4'b1100, 16'h0002, 16'h0003, 8'h00);
      wait_out(cyc, low);
      check("mul3_lat", cyc, 16);
      check("mul3_out", out, 16'h0006);
      check("mul3_flag", flag, 3'b000);

      // reset in the 5th busy cycle of a MUL
      op1("pre_rst_add", 4'b0001, 16'h8000, 16'h0001, 8'h00, 16'h8000, 3'b110);
      issue(4'b1100, 16'h0003, 16'hFFFE, 8'h00);
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rs_busy", busy, 1'b0);
      check("rs_rdy", in_ready, 1'b1);
      check("rs_flag", flag, 3'b000);
      check("rs_out", out, 16'h0000);
      count_pulses(20, pulses);
      check("rs_nopulse", pulses, 0);

      op1("ror", 4'b0110, 16'h8001, 16'h0001, 8'h00, 16'hC000, 3'b000);
      op1("ror0", 4'b0110, 16'h8001, 16'h0010, 8'h00, 16'h8001, 3'b000);
      op1("sll", 4'b0100, 16'h0001, 16'h000F, 8'h00, 16'h8000, 3'b000);
      op1("sra", 4'b0101, 16'h8000, 16'h0004, 8'h00, 16'hF800, 3'b000);
      op1("sll_z", 4'b0100, 16'h0100, 16'h0008, 8'h00, 16'h0000, 3'b001);
      op1("red", 4'b0011, 16'h1234, 16'hFFFF, 8'h00, 16'h0006, 3'b001);
      op1("red_neg", 4'b0011, 16'h8888, 16'h8888, 8'h00, 16'hFFC0, 3'b001);
      op1("llb", 4'b1011, 16'hABCD, 16'h0000, 8'h12, 16'hAB12, 3'b001);
      op1("lhb", 4'b1010, 16'hABCD, 16'h0000, 8'h12, 16'h12CD, 3'b001);
      op1("lw", 4'b1000, 16'h1001, 16'h0000, 8'hFF, 16'h0FFE, 3'b001);
      op1("sw", 4'b1001, 16'h0010, 16'h5555, 8'h02, 16'h0014, 3'b001);
      op1("illegal", 4'b1101, 16'h1234, 16'h5678, 8'h9A, 16'h0000, 3'b001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
